// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK-stage counter: FSM states, JK op codes and
// the per-cycle register mode chosen by the controller.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Op code bits are {J, K}, so a stage can be driven straight from the code.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_RELOAD = 2'b11
  } mode_e;

  function automatic jk_op_e load_op(input logic bit_val);
    return bit_val ? OP_SET : OP_RESET;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single rising-edge JK flip-flop stage with asynchronous active-low clear.
module jk_ff_cell
  import jk_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else begin
      unique case ({j_i, k_i})
        OP_HOLD:   q_q <= q_q;
        OP_RESET:  q_q <= 1'b0;
        OP_SET:    q_q <= 1'b1;
        default:   q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_count_seq.sv
// Up/down counter built from JK stages under an IDLE/RUN/DONE controller.
// Build option JK_SEQ_WRAP_EN: terminal count reloads and pulses tc_o instead of entering DONE.
module jk_count_seq
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] d_in_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             tc_o,
  output state_e           state_o
);

  // Control inputs are plain levels sampled on every rising edge; there is no
  // handshake, and every output is a register or a decode of a register.
  state_e           state_q, state_d;
  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] j, k;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

`ifdef JK_SEQ_WRAP_EN
  logic tc_q, tc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tc_q <= 1'b0;
    else         tc_q <= tc_d;
  end

  assign tc_o = tc_q;
`else
  assign tc_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode    = MODE_HOLD;
`ifdef JK_SEQ_WRAP_EN
    tc_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load_i)       mode    = MODE_LOAD;
        else if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Terminal test uses the pre-update value, so starting at term counts nothing.
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (q == term_i) begin
`ifdef JK_SEQ_WRAP_EN
          mode = MODE_RELOAD;
          tc_d = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end else begin
          mode = MODE_COUNT;
        end
      end
      ST_DONE: begin
        if (load_i) begin
          mode    = MODE_LOAD;
          state_d = ST_IDLE;
        end else if (stop_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit i toggles when all lower bits are ones (up) or zeros (down).
  always_comb begin
    logic chain;
    chain = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tgl[i] = chain;
      chain  = chain & (up_i ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    jk_op_e op;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode)
        MODE_LOAD:   op = load_op(d_in_i[i]);
        MODE_COUNT:  op = tgl[i] ? OP_TOGGLE : OP_HOLD;
        MODE_RELOAD: op = load_op(~up_i);
        default:     op = OP_HOLD;
      endcase
      {j[i], k[i]} = op;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    jk_ff_cell u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .j_i    (j[g]),
      .k_i    (k[g]),
      .q_o    (q[g])
    );
  end

  assign q_o     = q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_jk_count_seq.sv
// Self-checking bench for jk_count_seq (WIDTH=4); observed word is {tc, busy, done, q}.
module tb_jk_count_seq;
  import jk_seq_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         load = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] term = '0;
  logic [W-1:0] q;
  logic         busy, done, tc;
  state_e       state;

  logic [W+2:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail = 0;

  jk_count_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .stop_i  (stop),
    .load_i  (load),
    .up_i    (up),
    .d_in_i  (d_in),
    .term_i  (term),
    .q_o     (q),
    .busy_o  (busy),
    .done_o  (done),
    .tc_o    (tc),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    {load, start, stop} = 3'b000;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W+2:0] got;
    #2 rst_n = 1'b0;
    #1;
    got = {tc, busy, done, q};
    n_tests++;
    if (got !== 7'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_init got=%b state=%b exp=0000000 state=00", got, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [7:0]   stim [9];
    logic [W+2:0] expv [9];
    logic [W+2:0] got, exp_v;
    term = 4'd7;
    stim = '{8'b1_0_0_1_0011, 8'b0_1_0_1_0011, 8'b0_0_0_1_0011, 8'b0_0_0_1_0011,
             8'b0_0_0_1_0011, 8'b0_0_0_1_0011, 8'b0_0_0_1_0011, 8'b0_0_0_1_0011,
             8'b0_0_1_1_0011};
    expv = '{7'b0_0_0_0011, 7'b0_1_0_0011, 7'b0_1_0_0100, 7'b0_1_0_0101,
             7'b0_1_0_0110, 7'b0_1_0_0111, 7'b0_0_1_0111, 7'b0_0_1_0111,
             7'b0_0_0_0111};
    for (int i = 0; i < 9; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL count_up[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_count_down();
    logic [7:0]   stim [8];
    logic [W+2:0] expv [8];
    logic [W+2:0] got, exp_v;
    term = 4'd14;
    stim = '{8'b1_0_0_0_0010, 8'b0_1_0_0_0010, 8'b0_0_0_0_0010, 8'b0_0_0_0_0010,
             8'b0_0_0_0_0010, 8'b0_0_0_0_0010, 8'b0_0_0_0_0010, 8'b0_0_1_0_0010};
    expv = '{7'b0_0_0_0010, 7'b0_1_0_0010, 7'b0_1_0_0001, 7'b0_1_0_0000,
             7'b0_1_0_1111, 7'b0_1_0_1110, 7'b0_0_1_1110, 7'b0_0_0_1110};
    for (int i = 0; i < 8; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL count_down[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_stop_abort();
    logic [7:0]   stim [10];
    logic [W+2:0] expv [10];
    logic [W+2:0] got, exp_v;
    term = 4'd15;
    stim = '{8'b1_0_0_1_0010, 8'b0_1_0_1_0010, 8'b0_0_0_1_0010, 8'b0_0_0_1_0010,
             8'b0_0_1_1_0010, 8'b1_1_0_1_1011, 8'b0_0_0_1_1011, 8'b0_1_0_1_1011,
             8'b1_1_0_1_0000, 8'b0_0_1_1_0000};
    expv = '{7'b0_0_0_0010, 7'b0_1_0_0010, 7'b0_1_0_0011, 7'b0_1_0_0100,
             7'b0_0_0_0100, 7'b0_0_0_1011, 7'b0_0_0_1011, 7'b0_1_0_1011,
             7'b0_1_0_1100, 7'b0_0_0_1100};
    for (int i = 0; i < 10; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL stop_abort[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_term_start();
    logic [7:0]   stim [6];
    logic [W+2:0] expv [6];
    logic [W+2:0] got, exp_v;
    term = 4'd9;
    stim = '{8'b1_0_0_1_1001, 8'b0_1_0_1_1001, 8'b0_0_0_1_1001, 8'b0_1_0_1_1001,
             8'b1_0_0_1_0101, 8'b0_0_0_1_0101};
    expv = '{7'b0_0_0_1001, 7'b0_1_0_1001, 7'b0_0_1_1001, 7'b0_0_1_1001,
             7'b0_0_0_0101, 7'b0_0_0_0101};
    for (int i = 0; i < 6; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL term_start[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0]   stim [9];
    logic [W+2:0] expv [9];
    logic [W+2:0] got, exp_v;
    term = 4'd2;
    stim = '{8'b1_0_0_1_0000, 8'b0_1_0_1_0000, 8'b0_0_0_1_0000, 8'b0_0_0_1_0000,
             8'b0_0_0_1_0000, 8'b0_0_0_1_0000, 8'b0_0_0_1_0000, 8'b0_0_0_1_0000,
             8'b0_0_1_1_0000};
    expv = '{7'b0_0_0_0000, 7'b0_1_0_0000, 7'b0_1_0_0001, 7'b0_1_0_0010,
             7'b1_1_0_0000, 7'b0_1_0_0001, 7'b0_1_0_0010, 7'b1_1_0_0000,
             7'b0_0_0_0000};
    for (int i = 0; i < 9; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL wrap[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0]   stim [4];
    logic [W+2:0] expv [4];
    logic [W+2:0] got, exp_v;
    term = 4'd15;
    stim = '{8'b1_0_0_1_0011, 8'b0_1_0_1_0011, 8'b0_0_0_1_0011, 8'b0_0_0_1_0011};
    expv = '{7'b0_0_0_0011, 7'b0_1_0_0011, 7'b0_1_0_0100, 7'b0_1_0_0101};
    for (int i = 0; i < 4; i++) begin
      {load, start, stop, up, d_in} = stim[i];
      exp_q.push_back(expv[i]);
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_run_pre[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = {tc, busy, done, q};
    n_tests++;
    if (got !== 7'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_run_async got=%b state=%b exp=0000000 state=00", got, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    {load, start, stop, up, d_in} = 8'b1_0_0_1_0110;
    exp_q.push_back(7'b0_0_0_0110);
    tick();
    got   = {tc, busy, done, q};
    exp_v = exp_q.pop_front();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release_first_edge got=%b exp=%b", got, exp_v);
    end
  endtask

  // Behavioural reference: integer arithmetic and a three-state machine.
  task automatic test_random();
    int           m_st;
    int           m_q;
    logic         m_tc;
    logic [W+2:0] got, exp_v;
    apply_reset();
    m_st = 0;
    m_q  = 0;
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      up    = 1'($urandom_range(0, 1));
      d_in  = W'($urandom_range(0, 15));
      term  = W'($urandom_range(0, 15));
      m_tc  = 1'b0;
      case (m_st)
        0: begin
          if (load) m_q = int'(d_in);
          else if (start) m_st = 1;
        end
        1: begin
          if (stop) m_st = 0;
          else if (m_q == int'(term)) begin
`ifdef JK_SEQ_WRAP_EN
            m_q  = up ? 0 : 15;
            m_tc = 1'b1;
`else
            m_st = 2;
`endif
          end else begin
            m_q = up ? (m_q + 1) % 16 : (m_q + 15) % 16;
          end
        end
        default: begin
          if (load) begin
            m_q  = int'(d_in);
            m_st = 0;
          end else if (stop) m_st = 0;
        end
      endcase
      exp_q.push_back({m_tc, m_st == 1, m_st == 2, 4'(m_q)});
      tick();
      got   = {tc, busy, done, q};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef JK_SEQ_WRAP_EN
    test_wrap();
`else
    test_count_up();
    test_count_down();
    test_term_start();
`endif
    test_stop_abort();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
